// File: rtl/sonar_pkg.sv
// Shared types and default configuration for the sonar beam sweep scheduler.
package sonar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        BURST,
        LISTEN,
        REPORT
    } sweep_state_t;

    localparam int DEF_ANGLE_WIDTH   = 8;
    localparam int DEF_RANGE_WIDTH   = 16;
    localparam int DEF_ANGLE_MIN     = -30;
    localparam int DEF_ANGLE_MAX     = 30;
    localparam int DEF_ANGLE_STEP    = 10;
    localparam int DEF_SETTLE_CYCLES = 1024;
    localparam int DEF_BURST_CYCLES  = 524288;
    localparam int DEF_LISTEN_CYCLES = 16252928;

    // Largest of three cycle counts; sizes the shared dwell counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter with a terminal-count flag; one instance serves
// the settle, burst and listen phases of every dwell.
module dwell_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    // Load on phase entry, otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (count != '0)
            count <= count - WIDTH'(1);
    end

    assign done = (count == '0);

endmodule

// File: rtl/beam_sweep_scheduler.sv
// Sonar ping sequencer: steps the beam angle across the sweep and runs one
// settle/burst/listen/report dwell per angle, capturing the first echo.
// Optional: define SWEEP_EARLY_TERMINATE_EN to end LISTEN on the first echo.
module beam_sweep_scheduler
    import sonar_pkg::*;
#(
    parameter int ANGLE_WIDTH   = DEF_ANGLE_WIDTH,
    parameter int ANGLE_MIN     = DEF_ANGLE_MIN,
    parameter int ANGLE_MAX     = DEF_ANGLE_MAX,
    parameter int ANGLE_STEP    = DEF_ANGLE_STEP,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int BURST_CYCLES  = DEF_BURST_CYCLES,
    parameter int LISTEN_CYCLES = DEF_LISTEN_CYCLES,
    parameter int RANGE_WIDTH   = DEF_RANGE_WIDTH
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          enable_in,
    output logic signed [ANGLE_WIDTH-1:0] beam_angle_out,
    output logic                          burst_start_out,
    output logic                          burst_active_out,
    output logic                          listen_active_out,
    input  logic                          tof_valid_in,
    input  logic        [RANGE_WIDTH-1:0] range_in,
    output logic                          result_valid_out,
    output logic signed [ANGLE_WIDTH-1:0] result_angle_out,
    output logic        [RANGE_WIDTH-1:0] result_range_out,
    output logic                          result_hit_out,
    output logic                          sweep_done_out
);

    localparam int CNT_W = $clog2(max3(SETTLE_CYCLES, BURST_CYCLES, LISTEN_CYCLES)) + 1;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BURST_LOAD  = CNT_W'(BURST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LISTEN_LOAD = CNT_W'(LISTEN_CYCLES - 1);

    // Angle arithmetic is done one bit wider so the step can never overflow.
    localparam logic signed [ANGLE_WIDTH:0]   STEP_X = (ANGLE_WIDTH+1)'(ANGLE_STEP);
    localparam logic signed [ANGLE_WIDTH:0]   AMAX_X = (ANGLE_WIDTH+1)'(ANGLE_MAX);
    localparam logic signed [ANGLE_WIDTH-1:0] AMIN   = ANGLE_WIDTH'(ANGLE_MIN);

    sweep_state_t state, state_next;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic [CNT_W-1:0] tmr_count;
    logic             tmr_done;

    logic                   hit;
    logic [RANGE_WIDTH-1:0] range_latch;
    logic                   capture;
    logic                   listen_end;

    logic signed [ANGLE_WIDTH:0] angle_sum;
    logic                        wrap;

    dwell_timer #(.WIDTH(CNT_W)) u_timer (
        .clk        (clk_in),
        .rst_n      (rst_n_in),
        .load       (tmr_load),
        .load_value (tmr_value),
        .count      (tmr_count),
        .done       (tmr_done)
    );

    // Only the first echo of a dwell counts; BURST ringing is never sampled.
    assign capture = (state == LISTEN) && tof_valid_in && !hit;

`ifdef SWEEP_EARLY_TERMINATE_EN
    assign listen_end = tmr_done || capture;
`else
    assign listen_end = tmr_done;
`endif

    assign angle_sum = $signed({beam_angle_out[ANGLE_WIDTH-1], beam_angle_out}) + STEP_X;
    assign wrap      = angle_sum > AMAX_X;

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_next;
    end

    // Next state and timer reload; every transition reloads the timer.
    always_comb begin
        state_next = state;
        tmr_load   = 1'b0;
        tmr_value  = '0;
        unique case (state)
            IDLE: if (enable_in) begin
                state_next = SETTLE;
                tmr_load   = 1'b1;
                tmr_value  = SETTLE_LOAD;
            end
            SETTLE: if (tmr_done) begin
                state_next = BURST;
                tmr_load   = 1'b1;
                tmr_value  = BURST_LOAD;
            end
            BURST: if (tmr_done) begin
                state_next = LISTEN;
                tmr_load   = 1'b1;
                tmr_value  = LISTEN_LOAD;
            end
            LISTEN: if (listen_end) begin
                state_next = REPORT;
                tmr_load   = 1'b1;
            end
            REPORT: begin
                tmr_load = 1'b1;
                if (enable_in) begin
                    state_next = SETTLE;
                    tmr_value  = SETTLE_LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                tmr_load   = 1'b1;
            end
        endcase
    end

    // Echo latches: set by the first strobe in LISTEN, cleared leaving REPORT.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hit         <= 1'b0;
            range_latch <= '0;
        end else if (capture) begin
            hit         <= 1'b1;
            range_latch <= range_in;
        end else if (state == REPORT) begin
            hit         <= 1'b0;
            range_latch <= '0;
        end
    end

    // Result registers load on entry to REPORT, folding in a last-cycle echo.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            result_angle_out <= '0;
            result_range_out <= '0;
            result_hit_out   <= 1'b0;
        end else if (state == LISTEN && listen_end) begin
            result_angle_out <= beam_angle_out;
            result_range_out <= capture ? range_in : range_latch;
            result_hit_out   <= hit | capture;
        end
    end

    // Beam angle advances (or wraps to the start) as REPORT exits.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            beam_angle_out <= AMIN;
        else if (state == REPORT)
            beam_angle_out <= wrap ? AMIN : angle_sum[ANGLE_WIDTH-1:0];
    end

    assign burst_start_out   = (state == BURST) && (tmr_count == BURST_LOAD);
    assign burst_active_out  = (state == BURST);
    assign listen_active_out = (state == LISTEN);
    assign result_valid_out  = (state == REPORT);
    assign sweep_done_out    = (state == REPORT) && wrap;

endmodule

// File: tb/tb_beam_sweep_scheduler.sv
// Self-checking bench for beam_sweep_scheduler with a shortened schedule
// (settle 4, burst 8, listen 32, angles -30..30 step 10).
module tb_beam_sweep_scheduler;

    localparam int S   = 4;
    localparam int B   = 8;
    localparam int L   = 32;
    localparam int REP = S + B + L;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic signed [7:0] beam;
    logic              bs, ba, la;
    logic              tof;
    logic [15:0]       rng_in;
    logic              rv;
    logic signed [7:0] r_angle;
    logic [15:0]       r_range;
    logic              r_hit;
    logic              done;

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;

    always #5 clk = ~clk;

    beam_sweep_scheduler #(
        .ANGLE_WIDTH(8), .ANGLE_MIN(-30), .ANGLE_MAX(30), .ANGLE_STEP(10),
        .SETTLE_CYCLES(S), .BURST_CYCLES(B), .LISTEN_CYCLES(L), .RANGE_WIDTH(16)
    ) dut (
        .clk_in(clk), .rst_n_in(rst_n), .enable_in(en),
        .beam_angle_out(beam), .burst_start_out(bs), .burst_active_out(ba),
        .listen_active_out(la), .tof_valid_in(tof), .range_in(rng_in),
        .result_valid_out(rv), .result_angle_out(r_angle),
        .result_range_out(r_range), .result_hit_out(r_hit),
        .sweep_done_out(done)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    always @(posedge clk) ncyc++;

    // Reference model: a dwell is a position 0..REP inside the period;
    // phase boundaries follow directly from the cycle counts.
    bit m_act, m_hit, m_cap, rh;
    int m_pos, m_ang, m_rng, ra, rr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0; m_pos = 0; m_ang = -30; m_hit = 0; m_rng = 0;
            ra = 0; rr = 0; rh = 0;
        end else if (!m_act) begin
            if (en) begin m_act = 1; m_pos = 0; end
        end else if (m_pos == REP) begin
            m_ang = (m_ang + 10 > 30) ? -30 : m_ang + 10;
            m_hit = 0; m_rng = 0;
            m_act = en; m_pos = 0;
        end else begin
            m_cap = (m_pos >= S + B) && tof && !m_hit;
            if (m_cap) begin m_hit = 1; m_rng = int'(rng_in); end
`ifdef SWEEP_EARLY_TERMINATE_EN
            if (m_pos == REP - 1 || m_cap) begin
`else
            if (m_pos == REP - 1) begin
`endif
                m_pos = REP; ra = m_ang; rr = m_rng; rh = m_hit;
            end else begin
                m_pos++;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("beam_angle",    int'(beam), m_ang);
            chk("burst_start",   int'(bs), int'(m_act && m_pos == S));
            chk("burst_active",  int'(ba), int'(m_act && m_pos >= S && m_pos < S + B));
            chk("listen_active", int'(la), int'(m_act && m_pos >= S + B && m_pos < REP));
            chk("result_valid",  int'(rv), int'(m_act && m_pos == REP));
            chk("sweep_done",    int'(done), int'(m_act && m_pos == REP && m_ang + 10 > 30));
            chk("result_angle",  int'(r_angle), ra);
            chk("result_range",  int'(r_range), rr);
            chk("result_hit",    int'(r_hit), int'(rh));
        end
    end

    // Per-dwell observations filled in by run_dwell.
    int d_ang, d_rng, d_hit, d_done, d_bsn, d_bscnt, d_bc, d_lc, d_per;

    // Drives one dwell up to and including its REPORT cycle. s1/s2 are
    // listen-cycle indices for echo strobes (-1 = none).
    task automatic run_dwell(input int s1, input int r1, input int s2, input int r2,
                             input bit bstrobe, input bit drop);
        int lc = 0, bc = 0, n = 0;
        bit got = 0;
        d_bsn = -1; d_bscnt = 0;
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            tof = 1'b0;
            if (bs) begin d_bscnt++; if (d_bsn < 0) d_bsn = n; end
            if (ba) begin
                bc++;
                if (bstrobe && bc == 3) begin tof = 1'b1; rng_in = 16'd77; end
                if (drop && bc == 2) en = 1'b0;
            end
            if (la) begin
                if (lc == s1) begin tof = 1'b1; rng_in = 16'(r1); end
                if (lc == s2) begin tof = 1'b1; rng_in = 16'(r2); end
                lc++;
            end
            if (rv) begin
                got = 1;
                d_ang = int'(r_angle); d_rng = int'(r_range);
                d_hit = int'(r_hit);   d_done = int'(done);
            end
        end
        if (!got) chk("dwell_timeout", n, -1);
        d_bc = bc; d_lc = lc; d_per = n;
    endtask

    int vcount;
    int w;

    initial begin
        rst_n = 1'b0; en = 1'b0; tof = 1'b0; rng_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_beam",   int'(beam), -30);
        chk("rst_bs",     int'(bs), 0);
        chk("rst_ba",     int'(ba), 0);
        chk("rst_la",     int'(la), 0);
        chk("rst_rv",     int'(rv), 0);
        chk("rst_done",   int'(done), 0);
        chk("rst_rrange", int'(r_range), 0);
        chk("rst_rhit",   int'(r_hit), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        en = 1'b1;

        // Dwell -30: two echoes, only the first counts.
        run_dwell(10, 120, 20, 300, 0, 0);
        chk("d1_angle", d_ang, -30);
        chk("d1_range", d_rng, 120);
        chk("d1_hit",   d_hit, 1);
        chk("d1_bs_delay", d_bsn, 5);
        chk("d1_bs_width", d_bscnt, 1);
        chk("d1_burst_len", d_bc, 8);
`ifdef SWEEP_EARLY_TERMINATE_EN
        chk("d1_listen_len", d_lc, 11);
        chk("d1_period", d_per, 24);
        // Dwell -20: echo at listen cycle 5 ends the window early.
        run_dwell(5, 55, -1, 0, 0, 0);
        chk("d2_angle", d_ang, -20);
        chk("d2_range", d_rng, 55);
        chk("d2_hit",   d_hit, 1);
        chk("d2_period", d_per, 19);
`else
        chk("d1_listen_len", d_lc, 32);
        chk("d1_period", d_per, 45);
        // Dwell -20: silence.
        run_dwell(-1, 0, -1, 0, 0, 0);
        chk("d2_angle", d_ang, -20);
        chk("d2_range", d_rng, 0);
        chk("d2_hit",   d_hit, 0);
        chk("d2_period", d_per, 45);
`endif
        // Dwell -10: strobe only during the burst is ignored.
        run_dwell(-1, 0, -1, 0, 1, 0);
        chk("d3_angle", d_ang, -10);
        chk("d3_hit",   d_hit, 0);
        chk("d3_range", d_rng, 0);

        for (int a = 0; a <= 30; a += 10) begin
            run_dwell(-1, 0, -1, 0, 0, 0);
            chk("sweep_angle", d_ang, a);
            chk("sweep_done_flag", d_done, (a == 30) ? 1 : 0);
            chk("sweep_period", d_per, 45);
        end
        @(posedge clk); #1;
        chk("wrap_angle", int'(beam), -30);

        // Second pass: -30, -20, -10, then drop enable during the 0 burst.
        for (int a = -30; a <= -10; a += 10) begin
            run_dwell(-1, 0, -1, 0, 0, 0);
            chk("pass2_angle", d_ang, a);
        end
        run_dwell(-1, 0, -1, 0, 0, 1);
        chk("drop_angle", d_ang, 0);
        chk("drop_burst_len", d_bc, 8);
        chk("drop_listen_len", d_lc, 32);
        repeat (10) @(negedge clk);
        chk("idle_ba",   int'(ba), 0);
        chk("idle_beam", int'(beam), 10);
        en = 1'b1;
        run_dwell(-1, 0, -1, 0, 0, 0);
        chk("resume_angle", d_ang, 10);
        chk("resume_period", d_per, 45);

        // Asynchronous reset in the middle of the 20 dwell's listen window.
        w = 0;
        while (!la && w < 100) begin @(negedge clk); w++; end
        chk("reach_listen", int'(la), 1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_beam",   int'(beam), -30);
        chk("arst_la",     int'(la), 0);
        chk("arst_ba",     int'(ba), 0);
        chk("arst_rv",     int'(rv), 0);
        chk("arst_rangle", int'(r_angle), 0);
        chk("arst_rhit",   int'(r_hit), 0);
        @(negedge clk);
        rst_n = 1'b1;
        vcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (rv) vcount++;
        end
        chk("no_report_after_rst", vcount, 0);
        en = 1'b0;
        repeat (60) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
